// File: rtl/video_signal_generator.sv
// ============================================================================
// Module   : video_signal_generator
// Brief    : Free-running raster timing generator (sx/sy, syncs, de, frame
//            strobe, frame counter). Default timing is 1280x720@60.
// Options  : define VSG_SYNC_NEG_POL_EN for active-low hsync/vsync.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_signal_generator #(
  parameter int ACTIVE_H_PIXELS = 1280,
  parameter int H_FRONT_PORCH   = 110,
  parameter int H_SYNCH_WIDTH   = 40,
  parameter int H_BACK_PORCH    = 220,
  parameter int ACTIVE_LINES    = 720,
  parameter int V_FRONT_PORCH   = 5,
  parameter int V_SYNCH_WIDTH   = 5,
  parameter int V_BACK_PORCH    = 20,
  parameter int FPS             = 60,
  localparam int H_TOTAL = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNCH_WIDTH + H_BACK_PORCH,
  localparam int V_TOTAL = ACTIVE_LINES + V_FRONT_PORCH + V_SYNCH_WIDTH + V_BACK_PORCH,
  localparam int SX_W    = $clog2(H_TOTAL),
  localparam int SY_W    = $clog2(V_TOTAL),
  localparam int FC_W    = $clog2(FPS)
) (
  input  logic            i_clk_pxl,
  input  logic            i_reset_n,
  output logic [SX_W-1:0] o_sx,
  output logic [SY_W-1:0] o_sy,
  output logic            o_hsync,
  output logic            o_vsync,
  output logic            o_de,
  output logic            o_nf,
  output logic [FC_W-1:0] o_fc
);

  // Decode boundaries expressed at counter width so every compare is unsigned
  // and no wider than necessary.
  localparam logic [SX_W-1:0] C_H_LAST     = SX_W'(H_TOTAL - 1);
  localparam logic [SX_W-1:0] C_H_ACTIVE   = SX_W'(ACTIVE_H_PIXELS);
  localparam logic [SX_W-1:0] C_HS_START   = SX_W'(ACTIVE_H_PIXELS + H_FRONT_PORCH);
  localparam logic [SX_W-1:0] C_HS_END     = SX_W'(ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNCH_WIDTH - 1);
  localparam logic [SY_W-1:0] C_V_LAST     = SY_W'(V_TOTAL - 1);
  localparam logic [SY_W-1:0] C_V_ACTIVE   = SY_W'(ACTIVE_LINES);
  localparam logic [SY_W-1:0] C_VS_START   = SY_W'(ACTIVE_LINES + V_FRONT_PORCH);
  localparam logic [SY_W-1:0] C_VS_END     = SY_W'(ACTIVE_LINES + V_FRONT_PORCH + V_SYNCH_WIDTH - 1);
  localparam logic [FC_W-1:0] C_FC_LAST    = FC_W'(FPS - 1);

  logic [SX_W-1:0] r_sx;
  logic [SY_W-1:0] r_sy;
  logic [FC_W-1:0] r_fc;

  logic w_line_end;
  logic w_last_line;
  logic w_frame_end;
  logic w_h_active;
  logic w_v_active;
  logic w_hs_pulse;
  logic w_vs_pulse;

  assign w_line_end  = (r_sx == C_H_LAST);
  assign w_last_line = (r_sy == C_V_LAST);
  assign w_frame_end = w_line_end && w_last_line;

  always_ff @(posedge i_clk_pxl or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sx <= '0;
    end else if (w_line_end) begin
      r_sx <= '0;
    end else begin
      r_sx <= r_sx + SX_W'(1);
    end
  end

  always_ff @(posedge i_clk_pxl or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sy <= '0;
    end else if (w_frame_end) begin
      r_sy <= '0;
    end else if (w_line_end) begin
      r_sy <= r_sy + SY_W'(1);
    end
  end

  // Frame counter advances on the same edge that returns the raster to (0,0).
  always_ff @(posedge i_clk_pxl or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_fc <= '0;
    end else if (w_frame_end) begin
      if (r_fc == C_FC_LAST) begin
        r_fc <= '0;
      end else begin
        r_fc <= r_fc + FC_W'(1);
      end
    end
  end

  assign w_h_active = (r_sx < C_H_ACTIVE);
  assign w_v_active = (r_sy < C_V_ACTIVE);
  assign w_hs_pulse = (r_sx >= C_HS_START) && (r_sx <= C_HS_END);
  assign w_vs_pulse = (r_sy >= C_VS_START) && (r_sy <= C_VS_END);

  assign o_sx = r_sx;
  assign o_sy = r_sy;
  assign o_fc = r_fc;
  assign o_de = w_h_active && w_v_active;
  assign o_nf = w_frame_end;

`ifdef VSG_SYNC_NEG_POL_EN
  assign o_hsync = ~w_hs_pulse;
  assign o_vsync = ~w_vs_pulse;
`else
  assign o_hsync = w_hs_pulse;
  assign o_vsync = w_vs_pulse;
`endif

endmodule

`default_nettype wire

// File: tb/tb_video_signal_generator.sv
// ============================================================================
// Module   : tb_video_signal_generator
// Brief    : Self-checking bench for video_signal_generator (default and small
//            timing instances) against a position-from-cycle-count model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_video_signal_generator;

`ifdef VSG_SYNC_NEG_POL_EN
  localparam int NEG = 1;
`else
  localparam int NEG = 0;
`endif

  // Small timing: H_TOTAL=8, V_TOTAL=6, 48 cycles per frame.
  localparam int S_HA = 4, S_HFP = 1, S_HSW = 2, S_HBP = 1;
  localparam int S_VA = 3, S_VFP = 1, S_VSW = 1, S_VBP = 1, S_FPS = 3;
  localparam int D_HA = 1280, D_HFP = 110, D_HSW = 40, D_HBP = 220;
  localparam int D_VA = 720, D_VFP = 5, D_VSW = 5, D_VBP = 20, D_FPS = 60;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [10:0] d_sx;
  logic [9:0]  d_sy;
  logic [5:0]  d_fc;
  logic        d_hs, d_vs, d_de, d_nf;
  logic [2:0]  s_sx;
  logic [2:0]  s_sy;
  logic [1:0]  s_fc;
  logic        s_hs, s_vs, s_de, s_nf;

  int n_cmp = 0;
  int n_bad = 0;
  int n = 0;  // rising edges seen with reset released

  always #5 clk = ~clk;

  video_signal_generator u_dut_dflt (
    .i_clk_pxl (clk),
    .i_reset_n (rst_n),
    .o_sx      (d_sx),
    .o_sy      (d_sy),
    .o_hsync   (d_hs),
    .o_vsync   (d_vs),
    .o_de      (d_de),
    .o_nf      (d_nf),
    .o_fc      (d_fc)
  );

  video_signal_generator #(
    .ACTIVE_H_PIXELS (S_HA),
    .H_FRONT_PORCH   (S_HFP),
    .H_SYNCH_WIDTH   (S_HSW),
    .H_BACK_PORCH    (S_HBP),
    .ACTIVE_LINES    (S_VA),
    .V_FRONT_PORCH   (S_VFP),
    .V_SYNCH_WIDTH   (S_VSW),
    .V_BACK_PORCH    (S_VBP),
    .FPS             (S_FPS)
  ) u_dut_small (
    .i_clk_pxl (clk),
    .i_reset_n (rst_n),
    .o_sx      (s_sx),
    .o_sy      (s_sy),
    .o_hsync   (s_hs),
    .o_vsync   (s_vs),
    .o_de      (s_de),
    .o_nf      (s_nf),
    .o_fc      (s_fc)
  );

  typedef struct {
    int n;
    int sx, sy, hs, vs, de, nf, fc;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at n=%0d: got %0d, expected %0d", name, n, act, exp);
    end
  endtask

  // Expected outputs follow directly from elapsed cycles: position is the
  // cycle count split into line/pixel, frame number modulo FPS.
  task automatic check_inst(input string tag,
                            input int ha, input int hfp, input int hsw, input int hbp,
                            input int va, input int vfp, input int vsw, input int vbp,
                            input int fps,
                            input logic [31:0] sx, input logic [31:0] sy,
                            input logic [31:0] hs, input logic [31:0] vs,
                            input logic [31:0] de, input logic [31:0] nf,
                            input logic [31:0] fc);
    int ht, vt, e_sx, line, e_sy, e_fc, e_de, e_hs, e_vs, e_nf;
    ht   = ha + hfp + hsw + hbp;
    vt   = va + vfp + vsw + vbp;
    e_sx = n % ht;
    line = n / ht;
    e_sy = line % vt;
    e_fc = (line / vt) % fps;
    e_de = (e_sx < ha && e_sy < va) ? 1 : 0;
    e_hs = (e_sx >= ha + hfp && e_sx < ha + hfp + hsw) ? 1 : 0;
    e_vs = (e_sy >= va + vfp && e_sy < va + vfp + vsw) ? 1 : 0;
    e_nf = (e_sx == ht - 1 && e_sy == vt - 1) ? 1 : 0;
    chk({tag, ".sx"}, sx, e_sx);
    chk({tag, ".sy"}, sy, e_sy);
    chk({tag, ".fc"}, fc, e_fc);
    chk({tag, ".de"}, de, e_de);
    chk({tag, ".hsync"}, hs, e_hs ^ NEG);
    chk({tag, ".vsync"}, vs, e_vs ^ NEG);
    chk({tag, ".nf"}, nf, e_nf);
  endtask

  task automatic check_model();
    check_inst("dflt", D_HA, D_HFP, D_HSW, D_HBP, D_VA, D_VFP, D_VSW, D_VBP, D_FPS,
               32'(d_sx), 32'(d_sy), 32'(d_hs), 32'(d_vs), 32'(d_de), 32'(d_nf), 32'(d_fc));
    check_inst("small", S_HA, S_HFP, S_HSW, S_HBP, S_VA, S_VFP, S_VSW, S_VBP, S_FPS,
               32'(s_sx), 32'(s_sy), 32'(s_hs), 32'(s_vs), 32'(s_de), 32'(s_nf), 32'(s_fc));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) n++;
    @(negedge clk);
    check_model();
  endtask

  // Drop reset between edges, confirm outputs collapse before the next edge,
  // hold a few cycles, then release on a falling edge.
  task automatic async_reset(input int hold);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    n = 0;
    #1;
    check_model();
    for (int k = 0; k < hold; k++) tick();
    rst_n = 1'b1;
    tick();
    chk("restart.small.sx", 32'(s_sx), 1);
  endtask

  initial begin
    tbl[0]  = '{0,   0, 0, 0, 0, 1, 0, 0};
    tbl[1]  = '{4,   4, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{5,   5, 0, 1, 0, 0, 0, 0};
    tbl[3]  = '{6,   6, 0, 1, 0, 0, 0, 0};
    tbl[4]  = '{7,   7, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{8,   0, 1, 0, 0, 1, 0, 0};
    tbl[6]  = '{26,  2, 3, 0, 0, 0, 0, 0};
    tbl[7]  = '{34,  2, 4, 0, 1, 0, 0, 0};
    tbl[8]  = '{47,  7, 5, 0, 0, 0, 1, 0};
    tbl[9]  = '{48,  0, 0, 0, 0, 1, 0, 1};
    tbl[10] = '{143, 7, 5, 0, 0, 0, 1, 2};
    tbl[11] = '{144, 0, 0, 0, 0, 1, 0, 0};

    // Reset held for three cycles.
    rst_n = 1'b0;
    #1;
    check_model();
    for (int k = 0; k < 3; k++) tick();
    @(negedge clk);
    rst_n = 1'b1;
    check_model();

    for (int i = 0; i < 12; i++) begin
      while (n < tbl[i].n) tick();
      chk("tbl.sx", 32'(s_sx), tbl[i].sx);
      chk("tbl.sy", 32'(s_sy), tbl[i].sy);
      chk("tbl.hsync", 32'(s_hs), tbl[i].hs ^ NEG);
      chk("tbl.vsync", 32'(s_vs), tbl[i].vs ^ NEG);
      chk("tbl.de", 32'(s_de), tbl[i].de);
      chk("tbl.nf", 32'(s_nf), tbl[i].nf);
      chk("tbl.fc", 32'(s_fc), tbl[i].fc);
    end

    // Run into the third default line; small instance covers 61+ frames.
    while (n < 3800) tick();
    chk("dflt.pre_reset.sx", 32'(d_sx), 500);
    chk("dflt.pre_reset.sy", 32'(d_sy), 2);
    while (n < 3000 + 3800 - 3000) tick();
    async_reset(2);

    // Long run to exercise many small frames and the default hsync/wrap.
    while (n < 5000) tick();

    for (int r = 0; r < 3; r++) begin
      int len;
      len = $urandom_range(100, 4000);
      for (int k = 0; k < len; k++) tick();
      async_reset($urandom_range(0, 3));
    end
    for (int k = 0; k < 200; k++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/video_signal_generator.md
Name: video_signal_generator

Overview:
- Free-running raster timing generator for a pixel-clock domain.
- Produces the current screen position (sx, sy), horizontal/vertical sync, data-enable, a new-frame strobe and a frame counter.
- Default timing is 1280x720@60 (CEA-861 720p, 1650x750 total).
- Downstream consumers (text overlay, pattern generators, TMDS encoder) key off sx/sy and de.

Parameters:
- ACTIVE_H_PIXELS, 1280, visible pixels per line
- H_FRONT_PORCH, 110, pixels between active end and hsync start
- H_SYNCH_WIDTH, 40, hsync pulse width in pixels
- H_BACK_PORCH, 220, pixels between hsync end and line end
- ACTIVE_LINES, 720, visible lines per frame
- V_FRONT_PORCH, 5, lines between active end and vsync start
- V_SYNCH_WIDTH, 5, vsync pulse width in lines
- V_BACK_PORCH, 20, lines between vsync end and frame end
- FPS, 60, modulus of frame counter

Derived values:
- H_TOTAL = sum of the four horizontal parameters.
- V_TOTAL = sum of the four vertical parameters.

Ports:
- i_clk_pxl  in  1  pixel clock; all state changes on its rising edge
- i_reset_n  in  1  asynchronous active-low reset
- o_sx  out  $clog2(H_TOTAL)  current horizontal position (11 bits default)
- o_sy  out  $clog2(V_TOTAL)  current vertical position (10 bits default)
- o_hsync  out  1  horizontal sync, active-high
- o_vsync  out  1  vertical sync, active-high
- o_de  out  1  data enable, high inside the active area
- o_nf  out  1  new-frame strobe, one cycle
- o_fc  out  $clog2(FPS)  frame counter (6 bits default)

Behaviour:
- Reset is asynchronous and active-low. Asserting i_reset_n=0 immediately forces sx=0, sy=0, fc=0.
- While held in reset, counters stay at 0. Decoded outputs reflect position (0,0): de=1, hsync=0, vsync=0, nf=0.
- Counting starts on the first rising edge after i_reset_n is deasserted. Reset may be applied mid-frame; the next frame then starts at (0,0) with fc=0.
- Only sx, sy and fc are registered. hsync, vsync, de and nf are combinational decodes of the registered counters, so every output describes the same pixel (zero relative latency).
- sx increments every cycle. At H_TOTAL-1 it wraps to 0 and sy advances.
- sy wraps from V_TOTAL-1 to 0 simultaneously with the sx wrap at the last pixel of the frame.
- de = (sx < ACTIVE_H_PIXELS) && (sy < ACTIVE_LINES).
- hsync is high for sx in [HA+HFP, HA+HFP+HSW-1]. Default: 1390..1429.
- vsync is high for sy in [VA+VFP, VA+VFP+VSW-1], for full lines (all sx). Default: 725..729.
- nf is high for exactly one cycle, when sx=H_TOTAL-1 and sy=V_TOTAL-1. The following cycle is (0,0) of the next frame.
- fc increments on the same edge that wraps sy to 0. After FPS-1 it wraps to 0.
- Period: one line = H_TOTAL cycles (1650); one frame = H_TOTAL*V_TOTAL cycles (1,237,500).
- Arithmetic: counters are unsigned; comparisons use widths at least as wide as the counters. No counter ever exceeds its TOTAL-1.
- Parameters are elaboration-time only. Any porch or sync value must be ≥1. FPS must be ≥2.

Optional Feature:
- Macro VSG_SYNC_NEG_POL_EN.
- When defined: o_hsync and o_vsync are active-low, idle 1 and 0 during the pulse. Reset value of both is 1. All other outputs are unchanged.
- When not defined: active-high sync as described above.

Test Plan:
- Reset: hold i_reset_n=0 for 3 cycles, then release -> during reset sx=0, sy=0, fc=0, de=1, hsync=0, vsync=0, nf=0. One cycle after release, sx=1.
- Horizontal line: count cycles from sx=0 -> de high for 1280 cycles. hsync rises at sx=1390 and falls at sx=1430 (40 cycles). Wrap from 1649 to 0 with sy incrementing 0->1.
- Vertical frame: run one full frame -> de low for all sy≥720. vsync high exactly for sy=725..729. sy wraps 749->0.
- Frame strobe/counter: run 61 frames -> nf pulses once per frame at (1649,749), 1,237,500 cycles apart. fc goes 0..59 then 0 on the 61st frame start.
- Async reset mid-frame: drop i_reset_n at sx=500, sy=300 between clock edges -> outputs go to the reset values before the next edge. Restart from (0,0).
- Small parameters (ACTIVE_H_PIXELS=4, porches/sync=1/2/1, ACTIVE_LINES=3, V porches/sync=1/1/1, FPS=3) -> H_TOTAL=8, V_TOTAL=6. hsync at sx=5..6, vsync at sy=4. fc sequence 0,1,2,0.
